// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch buffer.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES    = 4;
    localparam int unsigned PC_READ_OFFSET = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is read straight from
// the storage flops so it is stable between pushes/pops.
import fetch_pkg::*;

module fetch_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Flush wins over a same-cycle push or pop.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch pointer, credit-based instruction memory requests and redirect flush in front of decode.
// Optional FETCH_BUF_STATS_EN adds a saturating flush_count of redirects.
import fetch_pkg::*;

module fetch_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [15:0] flush_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fpc_q, fpc_d;
    logic          pending_q, pending_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic [CW-1:0] count;
    logic [CW:0]   inflight;
    logic          issue, push, pop;
    fetch_entry_t  head, push_data;

    // Reserve a slot for the outstanding read so a response never meets a full FIFO.
    assign inflight = {1'b0, count} + {{CW{1'b0}}, pending_q};
    assign issue    = reset && !redirect && (inflight < (CW+1)'(DEPTH));
    assign push     = pending_q && !redirect;
    assign pop      = out_valid && out_ready;

    always_comb begin
        fpc_d        = fpc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        if (redirect) begin
            fpc_d = redirect_addr;
        end else if (issue) begin
            fpc_d        = fpc_q + 32'(INSTR_BYTES);
            pending_d    = 1'b1;
            pending_pc_d = fpc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc_q        <= RESET_ADDR;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            fpc_q        <= fpc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign push_data.instr = imem_rdata;
    assign push_data.pc    = pending_pc_q;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign imem_req     = issue;
    assign imem_addr    = fpc_q;
    assign out_valid    = (count != '0);
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus8 = head.pc + 32'(PC_READ_OFFSET);

`ifdef FETCH_BUF_STATS_EN
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        flush_count_d = flush_count_q;
        if (redirect && flush_count_q != 16'hFFFF) flush_count_d = flush_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) flush_count_q <= '0;
        else        flush_count_q <= flush_count_d;
    end

    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: startup latency, backpressure, redirect flush, reset and address wrap.
module tb_fetch_buffer;

    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset, redirect, out_ready;
    logic [31:0] redirect_addr;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus8;
    logic [31:0] rd_addr = '0;

    logic        imem_req2, out_valid2;
    logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2, out_pc_plus82;
    logic [31:0] rd_addr2 = '0;
`ifdef FETCH_BUF_STATS_EN
    logic [15:0] flush_count, flush_count2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Synchronous memory: data is a function of the address requested the previous cycle.
    always @(posedge clk) begin
        rd_addr  <= imem_addr;
        rd_addr2 <= imem_addr2;
    end
    assign imem_rdata  = rd_addr ^ K;
    assign imem_rdata2 = rd_addr2 ^ K;

    fetch_buffer #(.DEPTH(4), .RESET_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus8(out_pc_plus8)
`ifdef FETCH_BUF_STATS_EN
        , .flush_count(flush_count)
`endif
    );

    fetch_buffer #(.DEPTH(4), .RESET_ADDR(32'hFFFFFFF8)) dut2 (
        .clk(clk), .reset(reset), .redirect(1'b0), .redirect_addr(32'h0),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_pc_plus8(out_pc_plus82)
`ifdef FETCH_BUF_STATS_EN
        , .flush_count(flush_count2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; redirect = 1'b0; redirect_addr = '0; out_ready = 1'b1;
        cyc(); cyc(); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_pc",    out_pc,         32'h0);
        chk("rst_instr", out_instr,      32'h0);

        // Startup with decode always ready
        cyc(); reset = 1'b1; #1;
        chk("c0_req",   32'(imem_req),  32'd1);
        chk("c0_addr",  imem_addr,      32'h0);
        chk("c0_valid", 32'(out_valid), 32'd0);
        for (int c = 1; c <= 7; c++) begin
            cyc(); #1;
            chk("run_addr", imem_addr, 32'(4 * c));
            if (c == 1) begin
                chk("c1_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("run_valid", 32'(out_valid), 32'd1);
                chk("run_pc",    out_pc,         32'(4 * (c - 2)));
                chk("run_instr", out_instr,      32'(4 * (c - 2)) ^ K);
                chk("run_pc8",   out_pc_plus8,   32'(4 * (c - 2) + 8));
                chk("wrap_pc",   out_pc2,        32'hFFFFFFF8 + 32'(4 * (c - 2)));
            end
            if (c == 3) chk("wrap_pc8", out_pc_plus82, 32'h4);
        end

        // Redirect with three entries buffered and a read in flight
        cyc(); reset = 1'b0; out_ready = 1'b0; #1;
        cyc(); reset = 1'b1; #1;
        chk("r_c0_addr", imem_addr, 32'h0);
        cyc(); cyc(); cyc(); #1;
        chk("r_c3_addr", imem_addr, 32'hC);
        cyc(); redirect = 1'b1; redirect_addr = 32'h100; #1;
        chk("redir_req",  32'(imem_req), 32'd0);
        chk("redir_head", out_pc,        32'h0);
        cyc(); redirect = 1'b0; #1;
        chk("r1_req",   32'(imem_req),  32'd1);
        chk("r1_addr",  imem_addr,      32'h100);
        chk("r1_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("r2_valid", 32'(out_valid), 32'd0);
        chk("r2_addr",  imem_addr,      32'h104);
        cyc(); out_ready = 1'b1; #1;
        chk("r3_valid", 32'(out_valid), 32'd1);
        chk("r3_pc",    out_pc,         32'h100);
        chk("r3_instr", out_instr,      32'h100 ^ K);

        // Redirect coinciding with an accepted handshake
        cyc(); redirect = 1'b1; redirect_addr = 32'h200; #1;
        chk("hs_valid", 32'(out_valid), 32'd1);
        chk("hs_pc",    out_pc,         32'h104);
        chk("hs_req",   32'(imem_req),  32'd0);
        cyc(); redirect = 1'b0; #1;
        chk("hs1_valid", 32'(out_valid), 32'd0);
        chk("hs1_addr",  imem_addr,      32'h200);
        cyc(); #1;
        chk("hs2_valid", 32'(out_valid), 32'd0);
        cyc(); #1;
        chk("hs3_pc",  out_pc,       32'h200);
        chk("hs3_pc8", out_pc_plus8, 32'h208);
        cyc(); #1;
        chk("hs4_pc", out_pc, 32'h204);
`ifdef FETCH_BUF_STATS_EN
        chk("flush_cnt2", 32'(flush_count), 32'd2);
`endif

        // Fill the FIFO, then pulse reset for a single cycle
        cyc(); out_ready = 1'b0; #1;
        for (int i = 0; i < 6; i++) cyc();
        #1;
        chk("full_req",   32'(imem_req),  32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_pc",    out_pc,         32'h208);
        cyc(); reset = 1'b0; #1;
        chk("rpulse_req", 32'(imem_req), 32'd0);
        cyc(); reset = 1'b1; #1;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_req",   32'(imem_req),  32'd1);
        chk("post_addr",  imem_addr,      32'h0);

        // Backpressure from reset: four requests, then stall until decode drains
        for (int c = 1; c <= 3; c++) begin
            cyc(); #1;
            chk("bp_req",  32'(imem_req), 32'd1);
            chk("bp_addr", imem_addr,     32'(4 * c));
        end
        cyc(); #1;
        chk("bp4_req",   32'(imem_req),  32'd0);
        chk("bp4_valid", 32'(out_valid), 32'd1);
        chk("bp4_pc",    out_pc,         32'h0);
        cyc(); #1;
        chk("bp5_req",   32'(imem_req), 32'd0);
        chk("bp5_instr", out_instr,     32'h0 ^ K);
        cyc(); out_ready = 1'b1; #1;
        for (int c = 6; c <= 10; c++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc",    out_pc,         32'(4 * (c - 6)));
            if (c == 7) begin
                chk("resume_req",  32'(imem_req), 32'd1);
                chk("resume_addr", imem_addr,     32'h10);
            end
            if (c < 10) cyc();
            #1;
        end

`ifdef FETCH_BUF_STATS_EN
        redirect = 1'b1; redirect_addr = 32'h0;
        for (int i = 0; i < 70000; i++) cyc();
        redirect = 1'b0; #1;
        chk("flush_sat", 32'(flush_count), 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
